// File: rtl/imem_boot_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared definitions for the instruction-memory boot loader. This package
// holds the following items:
//   state_e               : loader FSM states
//   FRAME_HDR_BYTES       : number of length bytes at the front of a frame
//   BYTES_PER_WORD        : number of stream bytes in one instruction word
//   BYTE_IDX_W            : width of the byte-within-word counter
//   len_exceeds_capacity  : tests a frame length against the memory size
// ----------------------------------------------------------------------------
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    localparam int FRAME_HDR_BYTES = 2;
    localparam int BYTES_PER_WORD  = 4;
    localparam int BYTE_IDX_W      = $clog2(BYTES_PER_WORD);

    // A length of exactly 2**addr_w words is legal because it fills the memory.
    // Any larger length would force the word address to wrap, so it is rejected.
    function automatic logic len_exceeds_capacity(input logic [15:0]  len,
                                                  input int unsigned addr_w);
        logic [31:0] cap;
        cap = 32'd1 << addr_w;
        return ({16'd0, len} > cap);
    endfunction

endpackage : imem_boot_loader_pkg

// File: rtl/imem_boot_loader_if.sv
// ----------------------------------------------------------------------------
// imem_boot_loader_if
// Groups the byte-stream link, the instruction-memory write port and the
// loader status signals into one bundle.
//   slave  modport : the loader. It takes in the stream and drives the
//                    memory port and the status signals.
//   master modport : the byte source and the consumer of the memory port and
//                    status (the core, or a testbench).
// Signals:
//   in_valid, in_data[7:0], in_ready          byte stream handshake
//   imem_we, imem_addr[ADDR_W-1:0], imem_wdata instruction-memory write port
//   core_run, load_error, busy                 loader status
//   words_loaded[ADDR_W:0]                     count of words written
// ----------------------------------------------------------------------------
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              load_error;
    logic              busy;
    logic [ADDR_W:0]   words_loaded;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output core_run,
        output load_error,
        output busy,
        output words_loaded
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  core_run,
        input  load_error,
        input  busy,
        input  words_loaded
    );
endinterface : imem_boot_loader_if

// File: rtl/imem_boot_loader_word_assembler.sv
// ----------------------------------------------------------------------------
// imem_boot_loader_word_assembler
// Shifts accepted bytes into a 32-bit register, with the most significant byte
// arriving first. A 2-bit counter tracks the position of the byte within the
// word.
// Ports:
//   clock, reset_n    clock and asynchronous active-low reset
//   byte_valid        pulses for each accepted payload byte
//   byte_data[7:0]    the payload byte
//   word_last_byte    combinational. Goes high when this byte completes a word.
//   word_valid        registered pulse. High in the cycle after a word completes.
//   word_data[31:0]   the assembled word. It is valid while word_valid is high.
// ----------------------------------------------------------------------------
module imem_boot_loader_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_last_byte,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [BYTE_IDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [8*BYTES_PER_WORD-1:0] shift_q, shift_d;
    logic [8*BYTES_PER_WORD-1:0] shifted;
    logic                        word_valid_q, word_valid_d;

    // Each byte lane takes the lane below it. Lane 0 takes the new byte, so
    // after four shifts the first byte sits in the top lane.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi = gi + 1) begin : g_lane
            if (gi == 0) begin : g_in
                assign shifted[7:0] = byte_data;
            end else begin : g_mv
                assign shifted[8*gi +: 8] = shift_q[8*(gi-1) +: 8];
            end
        end
    endgenerate

    assign word_last_byte = byte_valid && (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    always_comb begin
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        word_valid_d = 1'b0;
        if (byte_valid) begin
            shift_d      = shifted;
            byte_idx_d   = byte_idx_q + 1'b1;
            word_valid_d = word_last_byte;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q      <= '0;
            byte_idx_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            word_valid_q <= word_valid_d;
        end
    end

    // The shift register keeps the complete word through the cycle after the
    // last byte. The next byte cannot change it before the following edge.
    assign word_valid = word_valid_q;
    assign word_data  = shift_q;

endmodule : imem_boot_loader_word_assembler

// File: rtl/imem_boot_loader.sv
// ----------------------------------------------------------------------------
// imem_boot_loader
// Receives a boot image as a byte stream and writes it into the instruction
// memory. The core is held stalled until the image checksum has been verified.
//
// A frame has this layout:
//   N[15:8], N[7:0], then 4*N payload bytes (each word MSB first),
//   then one checksum byte equal to the XOR of every preceding byte.
// Word i of the frame is written to word address i.
//
// If N is larger than 2**ADDR_W, or the checksum does not match, the loader
// sets load_error. A good frame sets core_run. Both states hold until reset.
//
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   bus (slave)      stream input, imem write port and status outputs.
//                    See imem_boot_loader_if for the signal list.
// ----------------------------------------------------------------------------
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    imem_boot_loader_if.slave  bus
);

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              core_run_q, core_run_d;
    logic              load_error_q, load_error_d;

    logic              accept;
    logic              load_accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   words_inc;
    logic              asm_last_byte;
    logic              asm_word_valid;
    logic [31:0]       asm_word;

    assign accept    = bus.in_valid && in_ready_q;
    assign len_full  = {len_hi_q, bus.in_data};
    assign words_inc = words_q + (ADDR_W+1)'(1);

    imem_boot_loader_word_assembler u_word_asm (
        .clock          (clock),
        .reset_n        (reset_n),
        .byte_valid     (load_accept),
        .byte_data      (bus.in_data),
        .word_last_byte (asm_last_byte),
        .word_valid     (asm_word_valid),
        .word_data      (asm_word)
    );

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        xor_d       = xor_q;
        words_d     = words_q;
        addr_d      = addr_q;
        load_accept = 1'b0;

        case (state_q)
            ST_LEN_HI: begin
                if (accept) begin
                    len_hi_d = bus.in_data;
                    xor_d    = xor_q ^ bus.in_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    xor_d = xor_q ^ bus.in_data;
                    if (len_exceeds_capacity(len_full, ADDR_W)) begin
                        state_d = ST_ERROR;
                    end else begin
                        // The range check above makes this truncation lossless.
                        len_d   = len_full[ADDR_W:0];
                        state_d = (len_full == 16'd0) ? ST_CHECK : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    load_accept = 1'b1;
                    xor_d       = xor_q ^ bus.in_data;
                    if (asm_last_byte) begin
                        // Latch the address of this word now, so that it lines
                        // up with the registered write strobe from the assembler.
                        addr_d  = words_q[ADDR_W-1:0];
                        words_d = words_inc;
                        if (words_inc == len_q) begin
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_d = (bus.in_data == xor_q) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN:   state_d = ST_RUN;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    // The status outputs are decoded from the next state, which makes them
    // registered and aligned with the state register.
    always_comb begin
        in_ready_d   = state_d inside {ST_LEN_HI, ST_LEN_LO, ST_LOAD, ST_CHECK};
        busy_d       = state_d inside {ST_LEN_LO, ST_LOAD, ST_CHECK};
        core_run_d   = (state_d == ST_RUN);
        load_error_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_LEN_HI;
            len_hi_q     <= '0;
            len_q        <= '0;
            xor_q        <= '0;
            words_q      <= '0;
            addr_q       <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            core_run_q   <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            xor_q        <= xor_d;
            words_q      <= words_d;
            addr_q       <= addr_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            core_run_q   <= core_run_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.imem_we      = asm_word_valid;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = asm_word;
    assign bus.core_run     = core_run_q;
    assign bus.load_error   = load_error_q;
    assign bus.busy         = busy_q;
    assign bus.words_loaded = words_q;

endmodule : imem_boot_loader

// File: tb/tb_imem_boot_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_boot_loader
// Drives boot frames into two loaders, one with ADDR_W=10 and one with
// ADDR_W=4. For each frame the bench builds the expected result directly
// from the frame description: the list of writes, the final run or error
// state, and the number of words loaded.
// ----------------------------------------------------------------------------
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic       drv_valid = 1'b0;
    logic [7:0] drv_data  = 8'd0;
    int         sel       = 10;

    imem_boot_loader_if #(.ADDR_W(10)) bus10 ();
    imem_boot_loader_if #(.ADDR_W(4))  bus4 ();

    assign bus10.in_valid = drv_valid && (sel == 10);
    assign bus10.in_data  = drv_data;
    assign bus4.in_valid  = drv_valid && (sel == 4);
    assign bus4.in_data   = drv_data;

    imem_boot_loader #(.ADDR_W(10)) dut10 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus10.slave)
    );

    imem_boot_loader #(.ADDR_W(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    // Outputs of whichever loader is currently selected.
    logic        o_ready, o_we, o_run, o_err, o_busy;
    logic [9:0]  o_addr;
    logic [31:0] o_wdata;
    logic [10:0] o_wl;

    always_comb begin
        if (sel == 4) begin
            o_ready = bus4.in_ready;
            o_we    = bus4.imem_we;
            o_run   = bus4.core_run;
            o_err   = bus4.load_error;
            o_busy  = bus4.busy;
            o_addr  = {6'd0, bus4.imem_addr};
            o_wdata = bus4.imem_wdata;
            o_wl    = {6'd0, bus4.words_loaded};
        end else begin
            o_ready = bus10.in_ready;
            o_we    = bus10.imem_we;
            o_run   = bus10.core_run;
            o_err   = bus10.load_error;
            o_busy  = bus10.busy;
            o_addr  = bus10.imem_addr;
            o_wdata = bus10.imem_wdata;
            o_wl    = bus10.words_loaded;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write log, sampled on the falling edge.
    int          wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clock) begin
        if (o_we === 1'b1) begin
            wr_addr.push_back(int'(o_addr));
            wr_data.push_back(o_wdata);
            chk("wl_at_write", 64'(o_wl), 64'(o_addr) + 64'd1);
        end
    end

    logic [31:0] words[$];
    logic [7:0]  frame[$];

    task automatic set_random_words(input int n);
        words = {};
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Frame = N (big-endian), words MSB first, XOR checksum (optionally corrupted).
    task automatic build_frame(input logic [7:0] flip);
        logic [15:0] nl;
        logic [7:0]  c;
        nl    = 16'(words.size());
        frame = {};
        frame.push_back(nl[15:8]);
        frame.push_back(nl[7:0]);
        foreach (words[i]) begin
            logic [31:0] w;
            w = words[i];
            frame.push_back(w[31:24]);
            frame.push_back(w[23:16]);
            frame.push_back(w[15:8]);
            frame.push_back(w[7:0]);
        end
        c = 8'd0;
        foreach (frame[i]) c = c ^ frame[i];
        frame.push_back(c ^ flip);
    endtask

    // Sends up to 'limit' bytes of the frame. Sending stops early once in_ready
    // drops. Before each byte there are random idle cycles, each taken with
    // probability gap_pct.
    task automatic send_frame(input int gap_pct, input int limit, output int sent);
        sent = 0;
        for (int i = 0; i < frame.size() && i < limit; i++) begin
            int tries;
            tries = 0;
            @(negedge clock);
            if (o_ready !== 1'b1) begin
                drv_valid = 1'b0;
                break;
            end
            while (tries < 1000 && int'($urandom_range(99)) < gap_pct) begin
                drv_valid = 1'b0;
                drv_data  = 8'($urandom);
                tries++;
                @(negedge clock);
            end
            drv_valid = 1'b1;
            drv_data  = frame[i];
            if (i == frame.size() - 1) chk("run_before_cks", 64'(o_run), 64'd0);
            @(posedge clock);
            sent++;
        end
        @(negedge clock);
        drv_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        drv_valid = 1'b0;
        reset_n   = 1'b0;
        @(negedge clock);
        reset_n   = 1'b1;
        wr_addr   = {};
        wr_data   = {};
    endtask

    task automatic run_frame(input string name, input int aw, input int gap_pct,
                             input logic [7:0] flip);
        int n, cap, sent, exp_sent, exp_wr, got_wr;
        bit too_big, exp_run;
        sel      = aw;
        n        = words.size();
        cap      = 1 << aw;
        build_frame(flip);
        too_big  = (n > cap);
        exp_run  = !too_big && (flip == 8'd0);
        exp_sent = too_big ? FRAME_HDR_BYTES : frame.size();
        exp_wr   = too_big ? 0 : n;
        wr_addr  = {};
        wr_data  = {};
        send_frame(gap_pct, frame.size(), sent);
        chk({name, ":sent"},  64'(sent), 64'(exp_sent));
        chk({name, ":run"},   64'(o_run), 64'(exp_run));
        chk({name, ":err"},   64'(o_err), 64'(!exp_run));
        chk({name, ":ready"}, 64'(o_ready), 64'd0);
        chk({name, ":busy"},  64'(o_busy), 64'd0);
        chk({name, ":wl"},    64'(o_wl), 64'(exp_wr));
        // Bytes offered after the final state must be ignored.
        for (int k = 0; k < 4; k++) begin
            drv_valid = 1'b1;
            drv_data  = 8'($urandom);
            @(negedge clock);
        end
        drv_valid = 1'b0;
        @(negedge clock);
        got_wr = wr_addr.size();
        chk({name, ":nwrites"}, 64'(got_wr), 64'(exp_wr));
        for (int i = 0; i < got_wr && i < exp_wr; i++) begin
            chk({name, ":addr"}, 64'(wr_addr[i]), 64'(i));
            chk({name, ":data"}, 64'(wr_data[i]), 64'(words[i]));
        end
        chk({name, ":run_sticky"}, 64'(o_run), 64'(exp_run));
        chk({name, ":err_sticky"}, 64'(o_err), 64'(!exp_run));
        $display("frame %s aw=%0d n=%0d gaps=%0d%% flip=%02h writes=%0d run=%b err=%b",
                 name, aw, n, gap_pct, flip, got_wr, o_run, o_err);
    endtask

    initial begin
        int sent;
        sel = 10;
        repeat (2) @(negedge clock);
        // Reset state
        chk("rst:ready", 64'(o_ready), 64'd1);
        chk("rst:we",    64'(o_we), 64'd0);
        chk("rst:run",   64'(o_run), 64'd0);
        chk("rst:err",   64'(o_err), 64'd0);
        chk("rst:busy",  64'(o_busy), 64'd0);
        chk("rst:wl",    64'(o_wl), 64'd0);
        reset_n = 1'b1;

        // 1: asynchronous reset right after the first word is written
        set_random_words(3);
        build_frame(8'd0);
        send_frame(0, FRAME_HDR_BYTES + 4, sent);
        chk("t1:we_before", 64'(o_we), 64'd1);
        chk("t1:busy_before", 64'(o_busy), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("t1:ready", 64'(o_ready), 64'd1);
        chk("t1:we",    64'(o_we), 64'd0);
        chk("t1:addr",  64'(o_addr), 64'd0);
        chk("t1:wdata", 64'(o_wdata), 64'd0);
        chk("t1:busy",  64'(o_busy), 64'd0);
        chk("t1:wl",    64'(o_wl), 64'd0);
        chk("t1:run",   64'(o_run), 64'd0);
        chk("t1:err",   64'(o_err), 64'd0);
        $display("reset mid-stream: ready=%b we=%b wl=%0d", o_ready, o_we, o_wl);
        @(negedge clock);
        reset_n = 1'b1;

        // 2: known two-word program, back-to-back bytes
        words = {32'h20080005, 32'h01095020};
        run_frame("t2_good", 10, 0, 8'd0);
        // 3: corrupted checksum
        do_reset();
        words = {32'h20080005, 32'h01095020};
        run_frame("t3_badcks", 10, 0, 8'h01);
        // 4: empty image
        do_reset();
        words = {};
        run_frame("t4_empty", 10, 0, 8'd0);
        // 5: capacity boundary on a 16-word memory
        do_reset();
        set_random_words(17);
        run_frame("t5_n17", 4, 0, 8'd0);
        do_reset();
        set_random_words(16);
        run_frame("t5_n16", 4, 0, 8'd0);
        // 6: the frame from test 2 with ~50% gaps
        do_reset();
        words = {32'h20080005, 32'h01095020};
        run_frame("t6_gaps", 10, 50, 8'd0);

        // Random frames on both memory sizes
        for (int r = 0; r < 10; r++) begin
            int aw, gp;
            logic [7:0] fl;
            do_reset();
            aw = ($urandom_range(1) == 0) ? 4 : 10;
            gp = int'($urandom_range(60));
            fl = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            set_random_words(int'($urandom_range(18)));
            run_frame($sformatf("rnd%0d", r), aw, gp, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_imem_boot_loader
